// File: rtl/dac_btn_ctrl_if.sv
// DAC write request channel: one value per request, held until the consumer acks.
interface dac_btn_ctrl_if;
    logic       wr_req;
    logic       wr_ch;
    logic [7:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, output wr_ch, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_ch, input wr_data, output wr_ack);
endinterface

// File: rtl/dac_btn_ctrl.sv
// Debounced buttons step two saturating 8-bit channels; changes are forwarded over req/ack.
// Press to wr_req: DB_CYCLES+4 edges when idle; presses during an unacked request coalesce.
module dac_btn_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            btn,
    input  logic                  add_sel,
    dac_btn_ctrl_if.master        wr,
    output logic [7:0]            led_out
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    logic [5:0]      s1_q, s2_q;
    logic [5:0]      deb_q, deb_d;
    logic [5:0]      deb_dly_q;
    logic [5:0]      press_q;
    logic [DB_W-1:0] cnt_q [6];
    logic [DB_W-1:0] cnt_d [6];

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            ch_q, ch_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      val_a_q, val_a_d;
    logic [7:0]      val_b_q, val_b_d;
    logic            dirty_a_q, dirty_a_d;
    logic            dirty_b_q, dirty_b_d;

    logic            step_vld;
    logic            step_up;
    logic [7:0]      step_mag;
    logic [7:0]      tgt_val;
    logic [8:0]      sum9, diff9;
    logic [7:0]      new_val;

    // A level is accepted only after DB_CYCLES consecutive samples disagree with it.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Highest-index press wins when several land in the same cycle.
    always_comb begin
        step_vld = |press_q;
        step_up  = 1'b0;
        step_mag = 8'd0;
        if (press_q[5]) begin
            step_up  = 1'b1;
            step_mag = 8'd1;
        end else if (press_q[4]) begin
            step_up  = 1'b1;
            step_mag = 8'd16;
        end else if (press_q[3]) begin
            step_up  = 1'b1;
            step_mag = 8'd64;
        end else if (press_q[2]) begin
            step_mag = 8'd1;
        end else if (press_q[1]) begin
            step_mag = 8'd16;
        end else if (press_q[0]) begin
            step_mag = 8'd64;
        end
    end

    always_comb begin
        tgt_val = add_sel ? val_b_q : val_a_q;
        sum9    = {1'b0, tgt_val} + {1'b0, step_mag};
        diff9   = {1'b0, tgt_val} - {1'b0, step_mag};
        if (step_up) begin
            new_val = sum9[8] ? 8'hFF : sum9[7:0];
        end else begin
            new_val = diff9[8] ? 8'h00 : diff9[7:0];
        end
    end

    // Dirty drops when a value is captured, so any press after capture (up to and
    // including the ack edge) leaves it set and triggers a follow-up write.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ch_d      = ch_q;
        data_d    = data_q;
        val_a_d   = val_a_q;
        val_b_d   = val_b_q;
        dirty_a_d = dirty_a_q;
        dirty_b_d = dirty_b_q;

        case (state_q)
            ST_IDLE: begin
                if (dirty_a_q) begin
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    ch_d      = 1'b0;
                    data_d    = val_a_q;
                    dirty_a_d = 1'b0;
                end else if (dirty_b_q) begin
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    ch_d      = 1'b1;
                    data_d    = val_b_q;
                    dirty_b_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (wr.wr_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (step_vld) begin
            if (add_sel) begin
                val_b_d   = new_val;
                dirty_b_d = 1'b1;
            end else begin
                val_a_d   = new_val;
                dirty_a_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            ch_q      <= 1'b0;
            data_q    <= 8'd0;
            val_a_q   <= 8'd0;
            val_b_q   <= 8'd0;
            dirty_a_q <= 1'b1;
            dirty_b_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
            val_a_q   <= val_a_d;
            val_b_q   <= val_b_d;
            dirty_a_q <= dirty_a_d;
            dirty_b_q <= dirty_b_d;
        end
    end

    assign wr.wr_req  = req_q;
    assign wr.wr_ch   = ch_q;
    assign wr.wr_data = data_q;
    assign led_out    = add_sel ? val_b_q : val_a_q;

endmodule

// File: tb/tb_dac_btn_ctrl.sv
// Directed bench for dac_btn_ctrl with a 4-sample debounce window.
module tb_dac_btn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       add_sel;
    logic [7:0] led_out;
    int         n_run  = 0;
    int         n_fail = 0;

    dac_btn_ctrl_if wr_if ();

    dac_btn_ctrl #(.DB_CYCLES(4), .DB_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .add_sel (add_sel),
        .wr      (wr_if),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for a request; optionally acks it for exactly one cycle.
    task automatic wait_req(input bit do_ack, output bit found, output logic ch, output logic [7:0] dat);
        found = 1'b0;
        ch    = 1'bx;
        dat   = 8'hxx;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (wr_if.wr_req === 1'b1) found = 1'b1;
        end
        if (found) begin
            ch  = wr_if.wr_ch;
            dat = wr_if.wr_data;
            if (do_ack) begin
                wr_if.wr_ack = 1'b1;
                @(negedge clk);
                wr_if.wr_ack = 1'b0;
            end
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        cycles(8);
        btn[idx] = 1'b0;
        cycles(8);
    endtask

    task automatic do_reset();
        bit f;
        logic c;
        logic [7:0] d;
        @(negedge clk);
        rst = 1'b1;
        btn = '0;
        wr_if.wr_ack = 1'b0;
        cycles(2);
        rst = 1'b0;
        wait_req(1'b1, f, c, d);
        wait_req(1'b1, f, c, d);
        cycles(2);
    endtask

    task automatic test_reset();
        bit f;
        logic c;
        logic [7:0] d;
        @(negedge clk);
        rst = 1'b1;
        btn = '0;
        add_sel = 1'b0;
        wr_if.wr_ack = 1'b0;
        cycles(2);
        n_run++; if (wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", wr_if.wr_req); end
        n_run++; if (wr_if.wr_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", wr_if.wr_ch); end
        n_run++; if (wr_if.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", wr_if.wr_data); end
        n_run++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led_out); end
        rst = 1'b0;
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL init_a: found=%0d ch=%b data=%h want ch=0 data=00", f, c, d); end
        n_run++; if (wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL req_drop_after_ack: got %b want 0", wr_if.wr_req); end
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h00) begin n_fail++; $display("FAIL init_b: found=%0d ch=%b data=%h want ch=1 data=00", f, c, d); end
        cycles(10);
        n_run++; if (wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL init_idle: req=%b want 0", wr_if.wr_req); end
        n_run++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL init_led: got %h want 00", led_out); end
    endtask

    task automatic test_debounce();
        bit f;
        logic c;
        logic [7:0] d;
        add_sel = 1'b0;
        btn[5] = 1'b1;
        cycles(2);
        btn[5] = 1'b0;
        cycles(15);
        n_run++; if (wr_if.wr_req !== 1'b0 || led_out !== 8'h00) begin n_fail++; $display("FAIL glitch: req=%b led=%h want req=0 led=00", wr_if.wr_req, led_out); end
        btn[5] = 1'b1;
        cycles(7);
        n_run++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL val_early_E6: led=%h want 00", led_out); end
        cycles(1);
        n_run++; if (led_out !== 8'h01 || wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL val_E7: led=%h req=%b want led=01 req=0", led_out, wr_if.wr_req); end
        cycles(1);
        n_run++; if (wr_if.wr_req !== 1'b1 || wr_if.wr_ch !== 1'b0 || wr_if.wr_data !== 8'h01) begin n_fail++; $display("FAIL req_E8: req=%b ch=%b data=%h want 1/0/01", wr_if.wr_req, wr_if.wr_ch, wr_if.wr_data); end
        wait_req(1'b1, f, c, d);
        btn[5] = 1'b0;
        cycles(15);
        n_run++; if (wr_if.wr_req !== 1'b0 || led_out !== 8'h01) begin n_fail++; $display("FAIL release_quiet: req=%b led=%h want req=0 led=01", wr_if.wr_req, led_out); end
    endtask

    task automatic test_sat_low();
        bit f;
        logic c;
        logic [7:0] d;
        add_sel = 1'b1;
        press(0);
        n_run++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL sat_low_led: got %h want 00", led_out); end
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h00) begin n_fail++; $display("FAIL sat_low_write: found=%0d ch=%b data=%h want ch=1 data=00", f, c, d); end
    endtask

    task automatic test_sat_high();
        bit f;
        logic c;
        logic [7:0] d;
        logic [7:0] exp_tbl [5] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hFF};
        do_reset();
        add_sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            press(3);
            wait_req(1'b1, f, c, d);
            n_run++; if (!f || c !== 1'b0 || d !== exp_tbl[k]) begin n_fail++; $display("FAIL sat_high_%0d: found=%0d ch=%b data=%h want ch=0 data=%h", k, f, c, d, exp_tbl[k]); end
        end
        press(1);
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'hEF) begin n_fail++; $display("FAIL sat_high_minus16: found=%0d ch=%b data=%h want ch=0 data=ef", f, c, d); end
    endtask

    task automatic test_coalesce();
        bit f;
        logic c;
        logic [7:0] d;
        do_reset();
        add_sel = 1'b0;
        press(4);
        wait_req(1'b0, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h10) begin n_fail++; $display("FAIL coal_first: found=%0d ch=%b data=%h want ch=0 data=10", f, c, d); end
        press(4);
        n_run++; if (wr_if.wr_req !== 1'b1 || wr_if.wr_data !== 8'h10) begin n_fail++; $display("FAIL coal_hold1: req=%b data=%h want 1/10", wr_if.wr_req, wr_if.wr_data); end
        press(4);
        n_run++; if (wr_if.wr_req !== 1'b1 || wr_if.wr_data !== 8'h10 || led_out !== 8'h30) begin n_fail++; $display("FAIL coal_hold2: req=%b data=%h led=%h want 1/10/30", wr_if.wr_req, wr_if.wr_data, led_out); end
        wait_req(1'b1, f, c, d);
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h30) begin n_fail++; $display("FAIL coal_second: found=%0d ch=%b data=%h want ch=0 data=30", f, c, d); end
        cycles(10);
        n_run++; if (wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL coal_only_one: req=%b want 0", wr_if.wr_req); end
    endtask

    task automatic test_priority_collision();
        bit f;
        logic c;
        logic [7:0] d;
        add_sel = 1'b1;
        press(5);
        wait_req(1'b0, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h01) begin n_fail++; $display("FAIL prio_b_first: found=%0d ch=%b data=%h want ch=1 data=01", f, c, d); end
        add_sel = 1'b0;
        press(5);
        add_sel = 1'b1;
        press(5);
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h01) begin n_fail++; $display("FAIL prio_b_held: found=%0d ch=%b data=%h want ch=1 data=01", f, c, d); end
        wait_req(1'b0, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h31) begin n_fail++; $display("FAIL prio_a_over_b: found=%0d ch=%b data=%h want ch=0 data=31", f, c, d); end
        add_sel = 1'b0;
        btn[5] = 1'b1;
        cycles(7);
        wr_if.wr_ack = 1'b1;
        @(negedge clk);
        wr_if.wr_ack = 1'b0;
        n_run++; if (wr_if.wr_req !== 1'b0 || led_out !== 8'h32) begin n_fail++; $display("FAIL collide_edge: req=%b led=%h want req=0 led=32", wr_if.wr_req, led_out); end
        btn[5] = 1'b0;
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h32) begin n_fail++; $display("FAIL collide_resend_a: found=%0d ch=%b data=%h want ch=0 data=32", f, c, d); end
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h02) begin n_fail++; $display("FAIL collide_then_b: found=%0d ch=%b data=%h want ch=1 data=02", f, c, d); end
        cycles(20);
        n_run++; if (wr_if.wr_req !== 1'b0) begin n_fail++; $display("FAIL collide_idle: req=%b want 0", wr_if.wr_req); end
    endtask

    task automatic test_reset_midreq();
        bit f;
        logic c;
        logic [7:0] d;
        add_sel = 1'b0;
        press(5);
        wait_req(1'b0, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h33) begin n_fail++; $display("FAIL midreq_setup: found=%0d ch=%b data=%h want ch=0 data=33", f, c, d); end
        rst = 1'b1;
        @(negedge clk);
        n_run++; if (wr_if.wr_req !== 1'b0 || wr_if.wr_data !== 8'h00) begin n_fail++; $display("FAIL midreq_drop: req=%b data=%h want 0/00", wr_if.wr_req, wr_if.wr_data); end
        wr_if.wr_ack = 1'b1;
        @(negedge clk);
        wr_if.wr_ack = 1'b0;
        rst = 1'b0;
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b0 || d !== 8'h00 || led_out !== 8'h00) begin n_fail++; $display("FAIL midreq_reinit_a: found=%0d ch=%b data=%h led=%h want ch=0 data=00 led=00", f, c, d, led_out); end
        wait_req(1'b1, f, c, d);
        n_run++; if (!f || c !== 1'b1 || d !== 8'h00) begin n_fail++; $display("FAIL midreq_reinit_b: found=%0d ch=%b data=%h want ch=1 data=00", f, c, d); end
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        add_sel = 1'b0;
        wr_if.wr_ack = 1'b0;
        test_reset();
        test_debounce();
        test_sat_low();
        test_sat_high();
        test_coalesce();
        test_priority_collision();
        test_reset_midreq();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
